shot_hit_detector: RTL and testbench
====================================

// Module: shot_hit_detector
// PURPOSE
//  Consumes the sprite pixel-plot stream (x, y, colour, plot) that feeds the VGA adapter.
//  On a shot request it captures the aim point, watches one full draw pass, and reports
//  hit or miss. Sits between the sprite drawers and game control, in parallel with the VGA adapter.
// PARAMETERS
//  RADIUS     2         hit window half-width in pixels, applied to both |dx| and |dy|
//  BG_COLOUR  3'b000    colour that never counts as a hit (background/erase pixels)
//  TIMEOUT    1048575   max cycles in ARMED+SCAN before a forced miss (20-bit counter)
// PORTS
//  clock        in   1  system clock (CLOCK_50 domain)
//  reset        in   1  synchronous, active-high
//  trigger      in   1  one-cycle shot request
//  shot_x       in   8  aim x, 0..159
//  shot_y       in   7  aim y, 0..119
//  pass_start   in   1  one-cycle pulse marking the first pixel of a draw pass
//  pass_end     in   1  one-cycle pulse marking the last pixel of a draw pass
//  plot         in   1  pixel valid
//  x            in   8  pixel x
//  y            in   7  pixel y
//  colour       in   3  pixel colour
//  busy         out  1  high in ARMED, SCAN, REPORT
//  hit          out  1  one-cycle pulse: shot hit
//  miss         out  1  one-cycle pulse: shot missed or timed out
//  hit_count    out  8  hits since reset, saturates at 255
// BEHAVIOUR
//  - Reset, synchronous, active-high: state IDLE; busy/hit/miss = 0; hit_count = 0; latches and timer cleared.
//  - States:
//    IDLE: trigger=1 -> latch shot_x/shot_y, clear hit_flag and timer, go to ARMED.
//    ARMED: pass_start=1 -> SCAN. A pixel in the pass_start cycle is evaluated.
//    SCAN: each cycle with plot=1 and colour != BG_COLOUR, test the pixel. If the
//      window test passes, set hit_flag (sticky). pass_end=1 -> REPORT; a pixel in the
//      pass_end cycle is evaluated.
//    REPORT: one cycle. Drive hit=hit_flag, miss=~hit_flag. On hit, hit_count+1, saturating. Go to IDLE.
//  - Window test: |x - sx| <= RADIUS and |y - sy| <= RADIUS.
//    Compute differences as 9-bit (x) and 8-bit (y) signed values. Never wrap modulo 256.
//  - Latency: hit/miss asserts exactly 1 cycle after the pass_end cycle.
//  - Timer: increments every cycle in ARMED and SCAN. At TIMEOUT, go to REPORT with hit_flag forced 0 (miss).
//  - trigger while busy: ignored; latched aim is unchanged.
//  - trigger in the same cycle as REPORT: ignored. A new shot needs a trigger in IDLE.
//  - pass_end in ARMED: ignored (partial pass).
//  - pass_start in SCAN: ignored; the scan continues.
//  - pass_start and pass_end in the same cycle while ARMED: single-pixel pass. Evaluate the pixel, then go to REPORT.
//  - hit and miss are never high together. Both are registered outputs.
//  - Reset mid-SCAN: abort with no hit/miss pulse and hit_count = 0.
// STRUCTURE
//  - Shared package duck_hunt_pkg holds:
//    - the state encoding localparams: IDLE, ARMED, SCAN, REPORT
//    - SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3
//    - BG_COLOUR default
//  - One sub-module, coord_window_cmp: combinational signed abs-diff compare of (x,y) against (sx,sy) within RADIUS.
//  - Everything else (FSM, latches, timer, counter) is in this module.
// TESTING
//  1. Hit: aim (40,30), RADIUS 2; pass contains plot (41,29) colour 111.
//     -> hit=1 exactly 1 cycle after pass_end; hit_count = 1.
//  2. Miss: aim (40,30); pass contains only (43,30) and (40,33).
//     -> miss pulse; hit_count unchanged.
//  3. Edge and background: aim (0,0); pixel (158,0) -> miss, no wrap.
//     Pixel (2,2) with colour 000 -> miss. Pixel (2,2) with colour 100 -> hit.
//  4. Timeout: TIMEOUT=15, trigger with no pass_start.
//     -> miss pulse 16 cycles after ARMED entry; busy drops the next cycle.
//  5. Protocol corners:
//     - trigger during SCAN with a new aim -> ignored; the original aim decides.
//     - pass_start+pass_end in the same cycle with a hit pixel -> hit.
//     - reset asserted mid-SCAN -> no pulse; busy=0 next cycle.
//  6. Saturation: 256 consecutive hits -> hit_count holds at 255.

Source files
------------

// File: rtl/duck_hunt_pkg.sv
// Shared duck-hunt definitions: screen geometry, pixel field widths,
// shot-detector state encoding and the default background colour.
package duck_hunt_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BG_COLOUR_DEF = 3'b000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SCAN   = 2'd2,
    REPORT = 2'd3
  } shot_state_t;

endpackage

// File: rtl/coord_window_cmp.sv
// Combinational hit-window test: |x - sx| <= RADIUS and |y - sy| <= RADIUS.
// Differences are one bit wider than the coordinates, so they never wrap.
module coord_window_cmp
  import duck_hunt_pkg::*;
#(
  parameter int RADIUS = 2
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [X_W-1:0] sx,
  input  logic [Y_W-1:0] sy,
  output logic           in_window
);

  localparam logic signed [X_W:0] R_X = (X_W+1)'(RADIUS);
  localparam logic signed [Y_W:0] R_Y = (Y_W+1)'(RADIUS);

  logic signed [X_W:0] dx, dx_abs;
  logic signed [Y_W:0] dy, dy_abs;

  function automatic logic signed [X_W:0] abs_x(input logic signed [X_W:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic signed [Y_W:0] abs_y(input logic signed [Y_W:0] v);
    return (v < 0) ? -v : v;
  endfunction

  assign dx        = $signed({1'b0, x}) - $signed({1'b0, sx});
  assign dy        = $signed({1'b0, y}) - $signed({1'b0, sy});
  assign dx_abs    = abs_x(dx);
  assign dy_abs    = abs_y(dy);
  assign in_window = (dx_abs <= R_X) && (dy_abs <= R_Y);

endmodule

// File: rtl/shot_hit_detector.sv
// Watches one sprite draw pass after a shot request and reports hit or miss;
// keeps a saturating count of hits since reset.
module shot_hit_detector
  import duck_hunt_pkg::*;
#(
  parameter int                   RADIUS    = 2,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = BG_COLOUR_DEF,
  parameter int unsigned          TIMEOUT   = 1048575
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trigger,
  input  logic [X_W-1:0]      shot_x,
  input  logic [Y_W-1:0]      shot_y,
  input  logic                pass_start,
  input  logic                pass_end,
  input  logic                plot,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                hit,
  output logic                miss,
  output logic [7:0]          hit_count
);

  localparam logic [19:0] TIMER_MAX = 20'(TIMEOUT);

  shot_state_t    state;
  logic [X_W-1:0] aim_x;
  logic [Y_W-1:0] aim_y;
  logic           hit_flag;
  logic [19:0]    timer;
  logic           in_window;
  logic           pix_hit;
  logic           timed_out;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  coord_window_cmp #(.RADIUS(RADIUS)) u_window (
    .x         (x),
    .y         (y),
    .sx        (aim_x),
    .sy        (aim_y),
    .in_window (in_window)
  );

  assign pix_hit   = plot && (colour != BG_COLOUR) && in_window;
  assign timed_out = (timer == TIMER_MAX);

  // hit/miss are registered on the edge that enters REPORT, so they are
  // visible in the cycle right after pass_end; the pass_end pixel is folded in.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      hit_count <= 8'd0;
      aim_x     <= '0;
      aim_y     <= '0;
      hit_flag  <= 1'b0;
      timer     <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            aim_x    <= shot_x;
            aim_y    <= shot_y;
            hit_flag <= 1'b0;
            timer    <= '0;
            busy     <= 1'b1;
            state    <= ARMED;
          end
        end
        ARMED: begin
          timer <= timer + 20'd1;
          if (timed_out) begin
            miss  <= 1'b1;
            state <= REPORT;
          end else if (pass_start) begin
            if (pass_end) begin
              hit   <= pix_hit;
              miss  <= ~pix_hit;
              if (pix_hit) hit_count <= sat_inc(hit_count);
              state <= REPORT;
            end else begin
              hit_flag <= pix_hit;
              state    <= SCAN;
            end
          end
        end
        SCAN: begin
          timer <= timer + 20'd1;
          if (timed_out) begin
            hit_flag <= 1'b0;
            miss     <= 1'b1;
            state    <= REPORT;
          end else if (pass_end) begin
            hit   <= hit_flag | pix_hit;
            miss  <= ~(hit_flag | pix_hit);
            if (hit_flag | pix_hit) hit_count <= sat_inc(hit_count);
            state <= REPORT;
          end else begin
            hit_flag <= hit_flag | pix_hit;
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shot_hit_detector.sv
// Directed bench for shot_hit_detector; TIMEOUT shortened to 15 cycles.
module tb_shot_hit_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger;
  logic [7:0] shot_x;
  logic [6:0] shot_y;
  logic       pass_start;
  logic       pass_end;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic       hit;
  logic       miss;
  logic [7:0] hit_count;

  int checks = 0;
  int errors = 0;

  shot_hit_detector #(.RADIUS(2), .BG_COLOUR(3'b000), .TIMEOUT(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .trigger    (trigger),
    .shot_x     (shot_x),
    .shot_y     (shot_y),
    .pass_start (pass_start),
    .pass_end   (pass_end),
    .plot       (plot),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .busy       (busy),
    .hit        (hit),
    .miss       (miss),
    .hit_count  (hit_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    trigger = 0; pass_start = 0; pass_end = 0; plot = 0;
    x = 0; y = 0; colour = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Trigger, then a two-pixel pass (pass_start pixel, pass_end pixel).
  task automatic shot2(input string tag, input logic [7:0] sx, input logic [6:0] sy,
                       input logic [7:0] ax, input logic [6:0] ay, input logic [2:0] ac,
                       input logic [7:0] bx, input logic [6:0] by, input logic [2:0] bc,
                       input logic exp_hit, input logic [7:0] exp_cnt);
    trigger = 1; shot_x = sx; shot_y = sy;
    tick();
    trigger = 0;
    pass_start = 1; plot = 1; x = ax; y = ay; colour = ac;
    tick();
    pass_start = 0; pass_end = 1; x = bx; y = by; colour = bc;
    tick();
    idle_in();
    check({tag, "_hit"}, hit, exp_hit);
    check({tag, "_miss"}, miss, !exp_hit);
    check({tag, "_count"}, hit_count, exp_cnt);
    tick();
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    idle_in();
    shot_x = 0; shot_y = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    check("reset_busy", busy, 0);
    check("reset_hit", hit, 0);
    check("reset_miss", miss, 0);
    check("reset_count", hit_count, 0);

    // Basic hit at (41,29) around aim (40,30)
    trigger = 1; shot_x = 40; shot_y = 30;
    tick();
    trigger = 0;
    check("t1_busy_armed", busy, 1);
    pass_start = 1; plot = 1; x = 10; y = 10; colour = 3'b111;
    tick();
    pass_start = 0; x = 41; y = 29;
    tick();
    plot = 0;
    check("t1_no_early_hit", hit, 0);
    pass_end = 1;
    tick();
    idle_in();
    check("t1_hit", hit, 1);
    check("t1_miss", miss, 0);
    check("t1_count", hit_count, 1);
    check("t1_busy_report", busy, 1);
    tick();
    check("t1_hit_pulse_end", hit, 0);
    check("t1_busy_idle", busy, 0);

    shot2("t2_miss", 40, 30, 43, 30, 3'b111, 40, 33, 3'b111, 0, 1);
    shot2("t3_nowrap", 0, 0, 158, 0, 3'b111, 158, 0, 3'b111, 0, 1);
    shot2("t3_bg", 0, 0, 2, 2, 3'b000, 2, 2, 3'b000, 0, 1);
    shot2("t3_fg", 0, 0, 2, 2, 3'b100, 2, 2, 3'b100, 1, 2);
    shot2("t3_corner_in", 40, 30, 42, 32, 3'b001, 38, 28, 3'b001, 1, 3);
    shot2("t3_corner_out", 40, 30, 43, 32, 3'b001, 38, 27, 3'b001, 0, 3);

    // Timeout: no pass_start at all
    trigger = 1; shot_x = 5; shot_y = 5;
    tick();
    trigger = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("t4_wait_miss", miss, 0);
      check("t4_wait_busy", busy, 1);
    end
    tick();
    check("t4_timeout_miss", miss, 1);
    check("t4_timeout_hit", hit, 0);
    check("t4_timeout_count", hit_count, 3);
    tick();
    check("t4_busy_drop", busy, 0);
    check("t4_miss_end", miss, 0);

    // Trigger during SCAN with a new aim is ignored
    trigger = 1; shot_x = 40; shot_y = 30;
    tick();
    trigger = 0; pass_start = 1;
    tick();
    pass_start = 0; trigger = 1; shot_x = 100; shot_y = 100;
    plot = 1; x = 100; y = 100; colour = 3'b111;
    tick();
    trigger = 0; plot = 0; pass_end = 1;
    tick();
    pass_end = 0;
    check("t5a_miss", miss, 1);
    check("t5a_hit", hit, 0);
    // Trigger coinciding with REPORT is ignored
    trigger = 1; shot_x = 1; shot_y = 1;
    tick();
    trigger = 0;
    check("t5a_report_trigger", busy, 0);
    tick();
    check("t5a_still_idle", busy, 0);

    // pass_end while ARMED is ignored
    trigger = 1; shot_x = 60; shot_y = 60;
    tick();
    trigger = 0; pass_end = 1;
    tick();
    pass_end = 0;
    check("t5_armed_pe_busy", busy, 1);
    check("t5_armed_pe_hit", hit, 0);
    check("t5_armed_pe_miss", miss, 0);
    pass_start = 1; plot = 1; x = 60; y = 60; colour = 3'b111;
    tick();
    idle_in(); pass_end = 1;
    tick();
    idle_in();
    check("t5_armed_pe_later_hit", hit, 1);
    check("t5_armed_pe_count", hit_count, 4);
    tick();

    // Single-pixel pass
    trigger = 1; shot_x = 50; shot_y = 50;
    tick();
    trigger = 0; pass_start = 1; pass_end = 1; plot = 1; x = 51; y = 52; colour = 3'b001;
    tick();
    idle_in();
    check("t5b_hit", hit, 1);
    check("t5b_count", hit_count, 5);
    tick();
    check("t5b_busy", busy, 0);

    // Reset mid-SCAN
    trigger = 1; shot_x = 20; shot_y = 20;
    tick();
    trigger = 0; pass_start = 1;
    tick();
    pass_start = 0; plot = 1; x = 20; y = 20; colour = 3'b111;
    tick();
    plot = 0; reset = 1;
    tick();
    reset = 0;
    check("t5c_busy", busy, 0);
    check("t5c_hit", hit, 0);
    check("t5c_miss", miss, 0);
    check("t5c_count", hit_count, 0);
    pass_end = 1;
    tick();
    pass_end = 0;
    check("t5c_no_pulse_hit", hit, 0);
    check("t5c_no_pulse_miss", miss, 0);

    // Saturation: 256 hits from zero
    for (int i = 0; i < 256; i++) begin
      trigger = 1; shot_x = 80; shot_y = 60;
      tick();
      trigger = 0; pass_start = 1; pass_end = 1; plot = 1; x = 80; y = 60; colour = 3'b010;
      tick();
      idle_in();
      if (i == 254) check("t6_count_255", hit_count, 255);
      if (i == 255) check("t6_last_hit", hit, 1);
      tick();
    end
    check("t6_saturated", hit_count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
